// File: rtl/ss_map_seq.sv
// Save-state initiator: walks mapper registers over the ss_* port into a byte buffer (SAVE) or back (LOAD).
// Optional macro SS_CSUM_EN adds an 8-bit modular checksum byte stored at buf[REG_COUNT].
module ss_map_seq #(
   parameter int REG_COUNT  = 128,
   parameter int STROBE_CYC = 2,
   parameter int IDX_ADDR   = 127
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_save,
   input  logic       start_load,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       ss_act,
   output logic       ss_we,
   output logic       ss_m2,
   output logic [7:0] ss_addr,
   output logic [7:0] ss_wdat,
   input  logic [7:0] ss_rdat,
   output logic [7:0] buf_addr,
   output logic       buf_we,
   output logic [7:0] buf_wdat,
   input  logic [7:0] buf_rdat
);

   typedef enum logic [3:0] {
      IDLE, S_RD, S_WR, S_CS, L_SUM, L_SCMP, L_IDX, L_CHK, L_FET, L_HI, L_LO, FIN, ERR
   } state_t;

   localparam logic [7:0] LAST_N  = 8'(REG_COUNT - 1);
   localparam logic [7:0] IDX_N   = 8'(IDX_ADDR);
   localparam logic [7:0] PH_LAST = 8'(STROBE_CYC - 1);
   localparam logic [7:0] FIRST_N = (IDX_ADDR == 0) ? 8'd1 : 8'd0;

`ifdef SS_CSUM_EN
   localparam state_t     LOAD_ENTRY = L_SUM;
   localparam state_t     SAVE_EXIT  = S_CS;
   localparam logic [7:0] CSUM_N     = 8'(REG_COUNT);
   logic [7:0] sum;
`else
   localparam state_t LOAD_ENTRY = L_IDX;
   localparam state_t SAVE_EXIT  = FIN;
`endif

   state_t     state, state_nxt;
   logic [7:0] n, cnt, wdat_q;
   logic [7:0] n_inc, n_skip;
   logic       ph_end, load_last, start_go;

   assign n_inc    = n + 8'd1;
   assign n_skip   = n + 8'd2;
   assign ph_end   = (cnt == PH_LAST);
   assign start_go = (state == IDLE) && (start_save || start_load);
   // The read-only index register is never written, so it may also end the walk.
   assign load_last = (n == LAST_N) || ((n_inc == IDX_N) && (n_inc == LAST_N));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      ss_act    = 1'b0;
      ss_we     = 1'b0;
      ss_m2     = 1'b1;
      ss_addr   = 8'd0;
      ss_wdat   = 8'd0;
      buf_addr  = 8'd0;
      buf_we    = 1'b0;
      buf_wdat  = 8'd0;
      if (state != IDLE && state != ERR) begin
         busy   = 1'b1;
         ss_act = 1'b1;
      end
      case (state)
         IDLE: begin
            if (start_save)      state_nxt = S_RD;
            else if (start_load) state_nxt = LOAD_ENTRY;
         end
         S_RD: begin
            ss_addr  = n;
            buf_addr = n;
            if (ph_end) state_nxt = S_WR;
         end
         S_WR: begin
            ss_addr   = n;
            buf_addr  = n;
            buf_we    = 1'b1;
            buf_wdat  = ss_rdat;
            state_nxt = (n == LAST_N) ? SAVE_EXIT : S_RD;
         end
`ifdef SS_CSUM_EN
         S_CS: begin
            buf_addr  = CSUM_N;
            buf_we    = 1'b1;
            buf_wdat  = sum;
            state_nxt = FIN;
         end
         L_SUM: begin
            buf_addr = n;
            if (n == CSUM_N) state_nxt = L_SCMP;
         end
         L_SCMP: begin
            buf_addr  = CSUM_N;
            state_nxt = (sum == buf_rdat) ? L_IDX : ERR;
         end
`endif
         L_IDX: begin
            ss_addr  = IDX_N;
            buf_addr = IDX_N;
            if (ph_end) state_nxt = L_CHK;
         end
         L_CHK: begin
            ss_addr   = IDX_N;
            buf_addr  = IDX_N;
            state_nxt = (ss_rdat == buf_rdat) ? L_FET : ERR;
         end
         L_FET: begin
            ss_addr   = n;
            buf_addr  = n;
            state_nxt = L_HI;
         end
         L_HI: begin
            ss_addr  = n;
            buf_addr = n;
            ss_we    = 1'b1;
            // Buffer data arrives this cycle; afterwards the captured copy is presented.
            ss_wdat  = (cnt == 8'd0) ? buf_rdat : wdat_q;
            if (ph_end) state_nxt = L_LO;
         end
         L_LO: begin
            ss_addr  = n;
            buf_addr = n;
            ss_we    = 1'b1;
            ss_m2    = 1'b0;
            ss_wdat  = wdat_q;
            if (ph_end) state_nxt = load_last ? FIN : L_FET;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n      <= 8'd0;
         cnt    <= 8'd0;
         wdat_q <= 8'd0;
         err    <= 1'b0;
      end else begin
         cnt <= (state_nxt == state) ? cnt + 8'd1 : 8'd0;
         if (start_go) begin
            n   <= 8'd0;
            err <= 1'b0;
         end
         if (state_nxt == ERR) err <= 1'b1;
         case (state)
            S_WR:  if (n != LAST_N) n <= n_inc;
`ifdef SS_CSUM_EN
            L_SUM: n <= (n == CSUM_N) ? 8'd0 : n_inc;
`endif
            L_CHK: n <= FIRST_N;
            L_HI:  if (cnt == 8'd0) wdat_q <= buf_rdat;
            L_LO:  if (ph_end && !load_last) n <= (n_inc == IDX_N) ? n_skip : n_inc;
            default: ;
         endcase
      end
   end

`ifdef SS_CSUM_EN
   // Buffer reads lag buf_addr by one cycle, so the pre-pass adds byte n-1 while addressing n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          sum <= 8'd0;
      else if (start_go)                   sum <= 8'd0;
      else if (state == S_WR)              sum <= sum + ss_rdat;
      else if (state == L_SUM && n != 8'd0) sum <= sum + buf_rdat;
   end
`endif

endmodule

// File: tb/tb_ss_map_seq.sv
// Self-checking bench for ss_map_seq: mapper and buffer models plus a spec-level reference of the expected results.
`timescale 1ns/1ps
module tb_ss_map_seq;

   localparam int REG_COUNT  = 128;
   localparam int STROBE_CYC = 2;
   localparam int IDX_ADDR   = 127;
   localparam int OP_BUDGET  = 3000;
`ifdef SS_CSUM_EN
   localparam int SAVE_LAT = REG_COUNT * (STROBE_CYC + 1) + 1;
`else
   localparam int SAVE_LAT = REG_COUNT * (STROBE_CYC + 1);
`endif
   localparam logic [7:0] IDX8 = 8'(IDX_ADDR);

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start_save = 1'b0;
   logic       start_load = 1'b0;
   logic       busy, done, err, ss_act, ss_we, ss_m2, buf_we;
   logic [7:0] ss_addr, ss_wdat, ss_rdat, buf_addr, buf_wdat, buf_rdat;

   int n_tests = 0;
   int n_fail  = 0;

   ss_map_seq #(.REG_COUNT(REG_COUNT), .STROBE_CYC(STROBE_CYC), .IDX_ADDR(IDX_ADDR)) dut (
      .clk(clk), .rst_n(rst_n), .start_save(start_save), .start_load(start_load),
      .busy(busy), .done(done), .err(err), .ss_act(ss_act), .ss_we(ss_we), .ss_m2(ss_m2),
      .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
      .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdat(buf_wdat), .buf_rdat(buf_rdat)
   );

   always #5 clk = ~clk;

   // Mapper model: reg 0 = prg, reg 1 = chr, IDX_ADDR = read-only index, everything else reads 0xFF.
   logic [7:0] m_prg, m_chr, m_idx, init_prg, init_chr, init_idx, fall_addr, fall_wdat;
   logic       model_init = 1'b0;
   logic       prev_m2;
   int         falls, idx_writes, strobe_viol;

   always_comb begin
      if (ss_addr == 8'd0)      ss_rdat = m_prg;
      else if (ss_addr == 8'd1) ss_rdat = m_chr;
      else if (ss_addr == IDX8) ss_rdat = m_idx;
      else                      ss_rdat = 8'hFF;
   end

   always @(negedge ss_m2 or negedge clk or posedge model_init) begin
      if (model_init) begin
         m_prg = init_prg; m_chr = init_chr; m_idx = init_idx;
         falls = 0; idx_writes = 0; strobe_viol = 0; prev_m2 = 1'b1;
         fall_addr = 8'd0; fall_wdat = 8'd0;
      end else begin
         if (rst_n && ss_act && ss_m2 === 1'b0) begin
            if (prev_m2) begin
               falls++;
               fall_addr = ss_addr;
               fall_wdat = ss_wdat;
               if (ss_we !== 1'b1) strobe_viol++;
               if (ss_addr == 8'd0)      m_prg = ss_wdat;
               else if (ss_addr == 8'd1) m_chr = ss_wdat;
               else if (ss_addr == IDX8) idx_writes++;
            end else if (ss_addr !== fall_addr || ss_wdat !== fall_wdat || ss_we !== 1'b1) begin
               strobe_viol++;
            end
         end
         prev_m2 = (ss_m2 === 1'b0) ? 1'b0 : 1'b1;
      end
   end

   // Buffer model with 1-cycle read latency; buf_init bulk-loads pre_mem while the DUT is idle.
   logic [7:0] mem [0:255];
   logic [7:0] pre_mem [0:255];
   logic       buf_init = 1'b0;

   always @(posedge clk) begin
      if (buf_init)    mem <= pre_mem;
      else if (buf_we) mem[buf_addr] <= buf_wdat;
      buf_rdat <= mem[buf_addr];
   end

   function automatic logic [7:0] exp_reg(input int a, input logic [7:0] p, c, i);
      if (a == 0) return p;
      if (a == 1) return c;
      if (a == IDX_ADDR) return i;
      return 8'hFF;
   endfunction

   task automatic set_model(input logic [7:0] p, c, i);
      init_prg = p; init_chr = c; init_idx = i;
      model_init = 1'b1;
      #1;
      model_init = 1'b0;
   endtask

   task automatic fill_pre_random();
      for (int a = 0; a < 256; a++) pre_mem[a] = 8'($urandom);
   endtask

   task automatic set_buf(input bit fix_csum);
      logic [7:0] s;
      s = 8'd0;
      for (int a = 0; a < REG_COUNT; a++) s += pre_mem[a];
      if (fix_csum) pre_mem[REG_COUNT] = s;
      @(negedge clk); buf_init = 1'b1;
      @(negedge clk); buf_init = 1'b0;
   endtask

   task automatic run_op(input bit do_save, input bit do_load, input int inject_at,
                         output int done_at, output int end_at, output int done_cnt, output int act_bad);
      int k;
      @(negedge clk); start_save = do_save; start_load = do_load;
      @(negedge clk); start_save = 1'b0; start_load = 1'b0;
      done_at = -1; done_cnt = 0; act_bad = 0;
      for (k = 0; k < OP_BUDGET; k++) begin
         start_load = (k == inject_at);
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (ss_act !== busy) act_bad++;
         if (busy !== 1'b1) break;
         @(negedge clk);
      end
      start_load = 1'b0;
      end_at = k;
      n_tests++;
      if (k >= OP_BUDGET) begin
         n_fail++;
         $display("FAIL op_timeout: busy still %b after %0d cycles", busy, k);
      end
   endtask

   task automatic check_save_buf(input string tag, input logic [7:0] p, c, i);
      int bad; logic [7:0] s; int first;
      bad = 0; s = 8'd0; first = -1;
      for (int a = 0; a < REG_COUNT; a++) begin
         s += exp_reg(a, p, c, i);
         if (mem[a] !== exp_reg(a, p, c, i)) begin
            bad++;
            if (first < 0) first = a;
         end
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s_buf: %0d bytes wrong, first at %0d got %h exp %h",
                  tag, bad, first, mem[first], exp_reg(first, p, c, i));
      end
`ifdef SS_CSUM_EN
      n_tests++;
      if (mem[REG_COUNT] !== s) begin
         n_fail++;
         $display("FAIL %s_csum: got %h exp %h", tag, mem[REG_COUNT], s);
      end
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      n_tests++;
      if ({busy, done, err, ss_act, ss_we, buf_we, ss_m2} !== 7'b0000001) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b exp 0000001", {busy, done, err, ss_act, ss_we, buf_we, ss_m2});
      end
      n_tests++;
      if ({ss_addr, buf_addr, ss_wdat, buf_wdat} !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h exp 0", {ss_addr, buf_addr, ss_wdat, buf_wdat});
      end
      rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      n_tests++;
      if ({busy, ss_act, ss_m2} !== 3'b001) begin
         n_fail++;
         $display("FAIL reset_idle: got %b exp 001", {busy, ss_act, ss_m2});
      end
   endtask

   task automatic test_save();
      int done_at, end_at, done_cnt, act_bad;
      set_model(8'h02, 8'h05, 8'hF4);
      fill_pre_random();
      set_buf(1'b0);
      run_op(1'b1, 1'b0, -1, done_at, end_at, done_cnt, act_bad);
      n_tests++;
      if (done_at != SAVE_LAT) begin
         n_fail++; $display("FAIL save_latency: got %0d exp %0d", done_at, SAVE_LAT);
      end
      n_tests++;
      if (done_cnt != 1 || end_at != done_at + 1) begin
         n_fail++; $display("FAIL save_done_pulse: pulses %0d busy_fall %0d done %0d", done_cnt, end_at, done_at);
      end
      n_tests++;
      if (falls != 0 || act_bad != 0 || err !== 1'b0) begin
         n_fail++; $display("FAIL save_side: falls %0d act_bad %0d err %b exp 0 0 0", falls, act_bad, err);
      end
      check_save_buf("save", 8'h02, 8'h05, 8'hF4);
   endtask

   task automatic test_load();
      int done_at, end_at, done_cnt, act_bad;
      set_model(8'h02, 8'h05, 8'hF4);
      fill_pre_random();
      pre_mem[0] = 8'h03; pre_mem[1] = 8'h06; pre_mem[IDX_ADDR] = 8'hF4;
      set_buf(1'b1);
      run_op(1'b0, 1'b1, -1, done_at, end_at, done_cnt, act_bad);
      n_tests++;
      if ({m_prg, m_chr, m_idx} !== {8'h03, 8'h06, 8'hF4}) begin
         n_fail++; $display("FAIL load_regs: got %h exp 0306f4", {m_prg, m_chr, m_idx});
      end
      n_tests++;
      if (falls != REG_COUNT - 1 || idx_writes != 0) begin
         n_fail++; $display("FAIL load_strobes: falls %0d idx_writes %0d exp %0d 0", falls, idx_writes, REG_COUNT - 1);
      end
      n_tests++;
      if (strobe_viol != 0 || act_bad != 0) begin
         n_fail++; $display("FAIL load_stable: viol %0d act_bad %0d exp 0", strobe_viol, act_bad);
      end
      n_tests++;
      if (done_cnt != 1 || end_at != done_at + 1 || err !== 1'b0) begin
         n_fail++; $display("FAIL load_done: pulses %0d fall %0d done %0d err %b", done_cnt, end_at, done_at, err);
      end
   endtask

   task automatic test_load_mismatch();
      int done_at, end_at, done_cnt, act_bad;
      set_model(8'h02, 8'h05, 8'hF4);
      fill_pre_random();
      pre_mem[0] = 8'h03; pre_mem[1] = 8'h06; pre_mem[IDX_ADDR] = 8'h04;
      set_buf(1'b1);
      run_op(1'b0, 1'b1, -1, done_at, end_at, done_cnt, act_bad);
      n_tests++;
      if (err !== 1'b1 || done_cnt != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL mismatch_err: err %b done %0d busy %b exp 1 0 0", err, done_cnt, busy);
      end
      n_tests++;
      if (falls != 0 || {m_prg, m_chr, m_idx} !== {8'h02, 8'h05, 8'hF4}) begin
         n_fail++; $display("FAIL mismatch_regs: falls %0d regs %h exp 0 0205f4", falls, {m_prg, m_chr, m_idx});
      end
      @(negedge clk);
      n_tests++;
      if (err !== 1'b1) begin
         n_fail++; $display("FAIL mismatch_sticky: err %b exp 1", err);
      end
      run_op(1'b1, 1'b0, -1, done_at, end_at, done_cnt, act_bad);
      n_tests++;
      if (err !== 1'b0 || done_cnt != 1) begin
         n_fail++; $display("FAIL err_clear: err %b done %0d exp 0 1", err, done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int done_at, end_at, done_cnt, act_bad;
      set_model(8'h02, 8'h05, 8'hF4);
      for (int a = 0; a < 256; a++) pre_mem[a] = 8'hAA;
      set_buf(1'b0);
      run_op(1'b1, 1'b1, -1, done_at, end_at, done_cnt, act_bad);
      n_tests++;
      if (done_at != SAVE_LAT || falls != 0) begin
         n_fail++; $display("FAIL both_start: latency %0d falls %0d exp %0d 0", done_at, falls, SAVE_LAT);
      end
      check_save_buf("both", 8'h02, 8'h05, 8'hF4);
      for (int a = 0; a < 256; a++) pre_mem[a] = 8'h55;
      set_buf(1'b0);
      run_op(1'b1, 1'b0, 100, done_at, end_at, done_cnt, act_bad);
      @(negedge clk); @(negedge clk);
      n_tests++;
      if (done_at != SAVE_LAT || falls != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL mid_load_ignored: latency %0d falls %0d busy %b", done_at, falls, busy);
      end
      check_save_buf("mid", 8'h02, 8'h05, 8'hF4);
   endtask

   task automatic test_reset_mid_load();
      int done_at, end_at, done_cnt, act_bad;
      bit found;
      set_model(8'h02, 8'h05, 8'hF4);
      fill_pre_random();
      pre_mem[0] = 8'h11; pre_mem[1] = 8'h22; pre_mem[IDX_ADDR] = 8'hF4;
      set_buf(1'b1);
      @(negedge clk); start_load = 1'b1;
      @(negedge clk); start_load = 1'b0;
      found = 1'b0;
      for (int k = 0; k < OP_BUDGET && !found; k++) begin
         if (ss_m2 === 1'b0 && ss_addr == 8'd1) found = 1'b1;
         else @(negedge clk);
      end
      n_tests++;
      if (!found) begin
         n_fail++; $display("FAIL rst_mid_reach: L_LO at n=1 seen %b exp 1", found);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({ss_m2, ss_act, busy} !== 3'b100) begin
         n_fail++; $display("FAIL rst_mid_abort: m2/act/busy %b exp 100", {ss_m2, ss_act, busy});
      end
      @(negedge clk); rst_n = 1'b1;
      set_model(8'h02, 8'h05, 8'hF4);
      run_op(1'b0, 1'b1, -1, done_at, end_at, done_cnt, act_bad);
      n_tests++;
      if (done_cnt != 1 || {m_prg, m_chr} !== {8'h11, 8'h22} || falls != REG_COUNT - 1) begin
         n_fail++; $display("FAIL rst_mid_restart: done %0d regs %h falls %0d exp 1 1122 %0d",
                            done_cnt, {m_prg, m_chr}, falls, REG_COUNT - 1);
      end
   endtask

   task automatic test_random();
      int done_at, end_at, done_cnt, act_bad;
      logic [7:0] p, c, i;
      bit good;
      for (int it = 0; it < 4; it++) begin
         p = 8'($urandom); c = 8'($urandom); i = 8'($urandom);
         set_model(p, c, i);
         fill_pre_random();
         set_buf(1'b0);
         run_op(1'b1, 1'b0, -1, done_at, end_at, done_cnt, act_bad);
         check_save_buf("rand_save", p, c, i);
         good = (it % 2 == 0);
         fill_pre_random();
         pre_mem[IDX_ADDR] = good ? i : (i ^ 8'(1 + $urandom_range(0, 254)));
         set_buf(1'b1);
         run_op(1'b0, 1'b1, -1, done_at, end_at, done_cnt, act_bad);
         n_tests++;
         if (good && ({m_prg, m_chr, m_idx} !== {pre_mem[0], pre_mem[1], i} || done_cnt != 1
                      || falls != REG_COUNT - 1 || err !== 1'b0 || strobe_viol != 0)) begin
            n_fail++; $display("FAIL rand_load_%0d: regs %h done %0d falls %0d err %b exp %h 1 %0d 0",
                               it, {m_prg, m_chr, m_idx}, done_cnt, falls, err, {pre_mem[0], pre_mem[1], i}, REG_COUNT - 1);
         end else if (!good && ({m_prg, m_chr, m_idx} !== {p, c, i} || done_cnt != 0 || falls != 0 || err !== 1'b1)) begin
            n_fail++; $display("FAIL rand_bad_%0d: regs %h done %0d falls %0d err %b exp %h 0 0 1",
                               it, {m_prg, m_chr, m_idx}, done_cnt, falls, err, {p, c, i});
         end
      end
   endtask

`ifdef SS_CSUM_EN
   task automatic test_checksum();
      int done_at, end_at, done_cnt, act_bad;
      set_model(8'h02, 8'h05, 8'hF4);
      fill_pre_random();
      set_buf(1'b0);
      run_op(1'b1, 1'b0, -1, done_at, end_at, done_cnt, act_bad);
      check_save_buf("csum_save", 8'h02, 8'h05, 8'hF4);
      for (int a = 0; a < 256; a++) pre_mem[a] = mem[a];
      pre_mem[0] = pre_mem[0] ^ 8'h01;
      set_buf(1'b0);
      run_op(1'b0, 1'b1, -1, done_at, end_at, done_cnt, act_bad);
      n_tests++;
      if (err !== 1'b1 || falls != 0 || done_cnt != 0) begin
         n_fail++; $display("FAIL csum_corrupt: err %b falls %0d done %0d exp 1 0 0", err, falls, done_cnt);
      end
   endtask
`endif

   initial begin
      set_model(8'h00, 8'h00, 8'h00);
      #2;
      test_reset();
      test_save();
      test_load();
      test_load_mismatch();
      test_back_to_back();
      test_reset_mid_load();
      test_random();
`ifdef SS_CSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
